multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have these ports, one clock and one reset; reset is synchronous and active-high:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register; stable from DECODE onward.
- funct  in  6  instruction[5:0] from the instruction register.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when ALU zero=1 (the datapath ANDs it with zero).
- pc_source  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write register select: 1 rd, 0 rt.
- mem_to_reg  out  1  writeback select: 1 memory data, 0 ALUOut.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU operand A select: 0 PC, 1 register A.
- alu_src_b  out  2  ALU operand B select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate<<2.
- alu_op  out  4  ALU control: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- instr_done  out  1  one-cycle pulse in the final cycle of each retired instruction.
- trap  out  1  an illegal opcode or funct was decoded.
- state  out  4  current state encoding, for debug.

Function
REQ-002 The block SHALL be a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, I_EXEC, I_WB, JUMP and TRAP.
REQ-003 Outputs SHALL decode combinationally from the state; only ir_write and pc_write in FETCH are additionally gated by mem_ready. Every output not listed for a state SHALL be 0.
REQ-004 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD and pc_source=00. It SHALL hold until mem_ready=1; in that cycle it SHALL drive ir_write=1 and pc_write=1 and go to DECODE.
REQ-005 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=ADD. It SHALL branch on opcode:
- 0x23 (lw) or 0x2B (sw) -> MEM_ADDR.
- 0x00 (R-type) -> R_EXEC.
- 0x04 (beq) -> BRANCH.
- 0x08 (addi) -> I_EXEC.
- 0x02 (j) -> JUMP.
- any other opcode -> TRAP.
REQ-006 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=ADD, then go to MEM_READ for lw or MEM_WRITE for sw.
REQ-007 MEM_READ SHALL drive mem_read=1 and i_or_d=1 and hold until mem_ready=1, then go to MEM_WB.
REQ-008 MEM_WB SHALL drive reg_dst=0, mem_to_reg=1, reg_write=1 and instr_done=1, then go to FETCH.
REQ-009 MEM_WRITE SHALL drive mem_write=1 and i_or_d=1 and hold until mem_ready=1. On that cycle it SHALL drive instr_done=1 and go to FETCH.
REQ-010 R_EXEC SHALL drive alu_src_a=1 and alu_src_b=00, with alu_op decoded from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Any other funct SHALL go to TRAP; otherwise the next state is R_WB.
REQ-011 R_WB SHALL drive reg_dst=1, mem_to_reg=0, reg_write=1 and instr_done=1, then go to FETCH.
REQ-012 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_source=01 and instr_done=1, then go to FETCH.
REQ-013 I_EXEC SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=ADD, then go to I_WB. I_WB SHALL match R_WB except reg_dst=0.
REQ-014 JUMP SHALL drive pc_write=1, pc_source=10 and instr_done=1, then go to FETCH.
REQ-015 TRAP SHALL drive trap=1 with all write strobes at 0, and SHALL stay in TRAP until reset.
REQ-016 Latency with mem_ready held at 1 SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles. Each memory wait cycle SHALL add exactly 1 cycle.
REQ-017 While waiting on mem_ready, every output SHALL hold stable and no write strobe other than the pending memory strobe SHALL assert.

Reset
REQ-018 When reset=1 at a clock edge, the state SHALL become FETCH and trap SHALL clear, regardless of the current state, including wait and TRAP states.
REQ-019 During any cycle with reset=1, pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read and instr_done SHALL be forced to 0.

Structure
REQ-020 A shared package SHALL hold the state enum, the opcode and funct constants, and the alu_op and alu_src_b encodings.
REQ-021 R-type funct-to-alu_op decoding SHALL live in one sub-module, alu_op_decoder, which is combinational and flags illegal funct values.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then opcode=0x23 with mem_ready=1 -> states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; instr_done high on cycle 5 only; reg_write=1, mem_to_reg=1.
- sw with mem_ready low for 3 cycles in MEM_WRITE -> mem_write held for 4 cycles; instr_done on the 4th; total 7 cycles.
- R-type, funct=0x22 -> alu_op=0110 in R_EXEC; reg_dst=1 and reg_write=1 in R_WB.
- beq -> pc_write_cond=1 and pc_source=01 in cycle 3; j -> pc_write=1 and pc_source=10 in cycle 3.
- opcode=0x3F -> TRAP with trap=1 held; R-type funct=0x3F -> TRAP.
- reset asserted during MEM_READ wait -> next state FETCH; strobes 0 during the reset cycle.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle controller: FSM state
// encoding, instruction opcode/funct values and datapath mux/ALU codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_I_EXEC    = 4'd9,
    ST_I_WB      = 4'd10,
    ST_JUMP      = 4'd11,
    ST_TRAP      = 4'd12
  } state_e;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle. The master side is the controller
// (drives control strobes and selects); the slave side is the datapath
// (supplies the instruction fields and the memory-ready indication).
//
// Handshake: the controller holds a memory strobe (mem_read/mem_write) and
// every other output stable until it samples mem_ready=1 on a rising edge;
// that cycle completes the access and the FSM advances on the same edge.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       instr_done;
  logic       trap;
  logic [3:0] state;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, trap, state
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, trap, state
  );
endinterface

// File: rtl/multicycle_controller_alu_op_decoder.sv
// R-type funct to ALU control decode. Purely combinational; flags any
// funct value the ALU does not implement so the FSM can trap on it.
module alu_op_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  // Map funct to ALU op; unknown codes report illegal and drive AND (0000).
  always_comb begin
    alu_op_o  = ALU_AND;
    illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_SLT:  alu_op_o = ALU_SLT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM. Moore outputs decode from the current
// state; only the FETCH-cycle IR/PC loads also depend on mem_ready. While
// reset is high every write/read strobe and instr_done are held at 0.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] r_alu_op;
  logic       r_illegal;

  logic       pc_write_c;
  logic       pc_write_cond_c;
  logic [1:0] pc_source_c;
  logic       i_or_d_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       reg_dst_c;
  logic       mem_to_reg_c;
  logic       reg_write_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [3:0] alu_op_c;
  logic       instr_done_c;
  logic       trap_c;

  alu_op_decoder u_alu_op_decoder (
    .funct_i   (bus.funct),
    .alu_op_o  (r_alu_op),
    .illegal_o (r_illegal)
  );

  // State register; reset wins from any state, including waits and TRAP.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = ST_R_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_I_EXEC;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_TRAP;
        endcase
      end
      // Only lw and sw reach MEM_ADDR, so anything but lw is a store.
      ST_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (bus.mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: if (bus.mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = r_illegal ? ST_TRAP : ST_R_WB;
      ST_R_WB:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_I_EXEC:    state_d = ST_I_WB;
      ST_I_WB:      state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_TRAP;
    endcase
  end

  // Per-state output decode; anything not set for a state stays 0.
  always_comb begin
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_source_c     = PCSRC_ALU;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    reg_dst_c       = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = SRCB_REG;
    alu_op_c        = ALU_AND;
    instr_done_c    = 1'b0;
    trap_c          = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        alu_op_c    = ALU_ADD;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
      end
      ST_DECODE: begin
        alu_src_b_c = SRCB_IMM_SH;
        alu_op_c    = ALU_ADD;
      end
      ST_MEM_ADDR, ST_I_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALU_ADD;
      end
      ST_MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
      end
      ST_MEM_WB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      ST_MEM_WRITE: begin
        mem_write_c  = 1'b1;
        i_or_d_c     = 1'b1;
        instr_done_c = bus.mem_ready;
      end
      ST_R_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = r_alu_op;
      end
      ST_R_WB: begin
        reg_dst_c    = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = ALU_SUB;
        pc_write_cond_c = 1'b1;
        pc_source_c     = PCSRC_ALUOUT;
        instr_done_c    = 1'b1;
      end
      ST_I_WB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      ST_JUMP: begin
        pc_write_c   = 1'b1;
        pc_source_c  = PCSRC_JUMP;
        instr_done_c = 1'b1;
      end
      ST_TRAP:  trap_c = 1'b1;
      default:  trap_c = 1'b1;
    endcase
  end

  assign bus.pc_write      = pc_write_c      & ~reset;
  assign bus.pc_write_cond = pc_write_cond_c & ~reset;
  assign bus.pc_source     = pc_source_c;
  assign bus.i_or_d        = i_or_d_c;
  assign bus.mem_read      = mem_read_c      & ~reset;
  assign bus.mem_write     = mem_write_c     & ~reset;
  assign bus.ir_write      = ir_write_c      & ~reset;
  assign bus.reg_dst       = reg_dst_c;
  assign bus.mem_to_reg    = mem_to_reg_c;
  assign bus.reg_write     = reg_write_c     & ~reset;
  assign bus.alu_src_a     = alu_src_a_c;
  assign bus.alu_src_b     = alu_src_b_c;
  assign bus.alu_op        = alu_op_c;
  assign bus.instr_done    = instr_done_c    & ~reset;
  assign bus.trap          = trap_c;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. The driver pushes the
// expected per-cycle output vector as it drives each cycle; the negedge
// monitor pops and compares against what the DUT shows.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MADDR = 4'd2;
  localparam logic [3:0] S_MREAD = 4'd3,  S_MWB    = 4'd4, S_MWRITE = 4'd5;
  localparam logic [3:0] S_REXEC = 4'd6,  S_RWB    = 4'd7, S_BRANCH = 4'd8;
  localparam logic [3:0] S_IEXEC = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11;
  localparam logic [3:0] S_TRAP  = 4'd12;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   done_cnt;
  int   mw_cnt;
  logic [3:0] cur_aop;

  logic [23:0] exp_q[$];
  string       tag_q[$];

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  wire [23:0] obs = {bus.state, bus.pc_write, bus.pc_write_cond, bus.pc_source,
                     bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                     bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_op, bus.instr_done, bus.trap};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs for one cycle, written from the state table.
  function automatic logic [23:0] exp_vec(input logic [3:0] st, input logic rdy,
                                          input logic rst, input logic [3:0] aop);
    logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, dn, tr;
    logic [1:0] ps, sb;
    logic [3:0] op;
    {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, dn, tr} = '0;
    ps = 2'b00; sb = 2'b00; op = 4'b0000;
    case (st)
      S_FETCH:  begin mr = 1; sb = 2'b01; op = 4'b0010; irw = rdy; pw = rdy; end
      S_DECODE: begin sb = 2'b11; op = 4'b0010; end
      S_MADDR:  begin sa = 1; sb = 2'b10; op = 4'b0010; end
      S_MREAD:  begin mr = 1; iod = 1; end
      S_MWB:    begin m2r = 1; rw = 1; dn = 1; end
      S_MWRITE: begin mw = 1; iod = 1; dn = rdy; end
      S_REXEC:  begin sa = 1; sb = 2'b00; op = aop; end
      S_RWB:    begin rd = 1; rw = 1; dn = 1; end
      S_BRANCH: begin sa = 1; op = 4'b0110; pwc = 1; ps = 2'b01; dn = 1; end
      S_IEXEC:  begin sa = 1; sb = 2'b10; op = 4'b0010; end
      S_IWB:    begin rw = 1; dn = 1; end
      S_JUMP:   begin pw = 1; ps = 2'b10; dn = 1; end
      S_TRAP:   tr = 1;
      default:  tr = 1;
    endcase
    if (rst) begin pw = 0; pwc = 0; irw = 0; rw = 0; mw = 0; mr = 0; dn = 0; end
    return {st, pw, pwc, ps, iod, mr, mw, irw, rd, m2r, rw, sa, sb, op, dn, tr};
  endfunction

  function automatic logic [3:0] fn_aop(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  // Scoreboard monitor: compare away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_eq(tag_q.pop_front(), {8'h0, obs}, {8'h0, exp_q.pop_front()});
    done_cnt += int'(bus.instr_done);
    mw_cnt   += int'(bus.mem_write);
  end

  // Driver: one cycle; st is the state the DUT should be in this cycle.
  task automatic drive(input logic rst, input logic rdy, input logic [3:0] st,
                       input bit chk, input string tag);
    @(posedge clk);
    #1;
    reset = rst;
    bus.mem_ready = rdy;
    if (chk) begin
      exp_q.push_back(exp_vec(st, rdy, rst, cur_aop));
      tag_q.push_back($sformatf("%s_st%0d", tag, st));
    end
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mwait, input string tag);
    int d0, m0;
    bus.opcode = op;
    bus.funct  = fn;
    cur_aop    = fn_aop(fn);
    d0 = done_cnt;
    m0 = mw_cnt;
    repeat (fw) drive(0, 0, S_FETCH, 1, tag);
    drive(0, 1, S_FETCH, 1, tag);
    drive(0, rnd(), S_DECODE, 1, tag);
    case (op)
      6'h23: begin
        drive(0, rnd(), S_MADDR, 1, tag);
        repeat (mwait) drive(0, 0, S_MREAD, 1, tag);
        drive(0, 1, S_MREAD, 1, tag);
        drive(0, rnd(), S_MWB, 1, tag);
      end
      6'h2B: begin
        drive(0, rnd(), S_MADDR, 1, tag);
        repeat (mwait) drive(0, 0, S_MWRITE, 1, tag);
        drive(0, 1, S_MWRITE, 1, tag);
      end
      6'h00: begin
        drive(0, rnd(), S_REXEC, 1, tag);
        drive(0, rnd(), S_RWB, 1, tag);
      end
      6'h04: drive(0, rnd(), S_BRANCH, 1, tag);
      6'h08: begin
        drive(0, rnd(), S_IEXEC, 1, tag);
        drive(0, rnd(), S_IWB, 1, tag);
      end
      default: drive(0, rnd(), S_JUMP, 1, tag);
    endcase
    @(negedge clk);
    #1;
    check_eq({tag, "_done"}, done_cnt - d0, 1);
    check_eq({tag, "_mwcnt"}, mw_cnt - m0, (op == 6'h2B) ? mwait + 1 : 0);
  endtask

  // Enter TRAP, sit there, then leave through reset.
  task automatic trap_seq(input logic [5:0] op, input logic [5:0] fn, input string tag);
    bus.opcode = op;
    bus.funct  = fn;
    cur_aop    = fn_aop(fn);
    drive(0, 1, S_FETCH, 1, tag);
    drive(0, rnd(), S_DECODE, 1, tag);
    if (op == 6'h00) drive(0, rnd(), S_REXEC, 0, tag);
    repeat (3) drive(0, rnd(), S_TRAP, 1, tag);
    drive(1, 1, S_TRAP, 1, {tag, "_rst"});
    drive(0, 0, S_FETCH, 1, {tag, "_post"});
  endtask

  logic [5:0] ops[6] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
  logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    total = 0; bad = 0; done_cnt = 0; mw_cnt = 0; cur_aop = 4'b0;
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'h00;
    bus.funct  = 6'h20;
    drive(1, 1, S_FETCH, 0, "init");
    drive(1, 1, S_FETCH, 0, "init");
    drive(1, 1, S_FETCH, 1, "reset");

    run_instr(6'h23, 6'h00, 0, 0, "lw");
    run_instr(6'h2B, 6'h00, 0, 3, "sw_wait");
    foreach (fns[i]) run_instr(6'h00, fns[i], 0, 0, $sformatf("r_%h", fns[i]));
    run_instr(6'h04, 6'h00, 0, 0, "beq");
    run_instr(6'h02, 6'h00, 0, 0, "j");
    run_instr(6'h08, 6'h00, 2, 0, "addi_fw");
    run_instr(6'h23, 6'h00, 1, 2, "lw_wait");

    for (int k = 0; k < 10; k++) begin
      run_instr(ops[$urandom_range(0, 5)], fns[$urandom_range(0, 4)],
                $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd%0d", k));
    end

    // Reset while waiting on a load.
    bus.opcode = 6'h23;
    drive(0, 1, S_FETCH, 1, "rstw");
    drive(0, 1, S_DECODE, 1, "rstw");
    drive(0, 1, S_MADDR, 1, "rstw");
    drive(0, 0, S_MREAD, 1, "rstw");
    drive(1, 0, S_MREAD, 1, "rstw_rst");
    drive(0, 0, S_FETCH, 1, "rstw_post");

    trap_seq(6'h3F, 6'h20, "trap_op");
    trap_seq(6'h00, 6'h3F, "trap_fn");

    run_instr(6'h23, 6'h00, 0, 0, "lw_end");

    @(negedge clk);
    #1;
    check_eq("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
